// File: rtl/switch_debouncer.sv
// Multi-channel switch conditioner: synchronise, hold-qualify, emit level + one-cycle pulse.
// Optional macro SWITCH_DEBOUNCER_RELEASE_DEBOUNCE_EN adds a debounced release (RELEASING state).
module switch_debouncer #(
  parameter int                  CHANNELS    = 2,
  parameter int                  HOLD_CYCLES = 1023,
  parameter int                  CNT_W       = 10,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW  = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] sw_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] pulse_out,
  output logic                any_active
);

`ifdef SWITCH_DEBOUNCER_RELEASE_DEBOUNCE_EN
  typedef enum logic [1:0] {IDLE, ARMING, ACTIVE, RELEASING} state_t;
`else
  typedef enum logic [1:0] {IDLE, ARMING, ACTIVE} state_t;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam bit               SINGLE   = (HOLD_CYCLES == 1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   act;
    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   level_q, level_nxt;
    logic                   pulse_q, pulse_nxt;

    // Polarity is folded in ahead of the chain, so a reset chain always reads "inactive".
    always_ff @(posedge clock or posedge reset) begin
      if (reset) sync <= '0;
      else       sync <= {sync[SYNC_STAGES-2:0], sw_in[i] ^ ACTIVE_LOW[i]};
    end

    assign act = sync[SYNC_STAGES-1];

    always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      state_nxt = state;
      cnt_nxt   = cnt;
      pulse_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (act) begin
            if (SINGLE) begin
              state_nxt = ACTIVE;
              pulse_nxt = 1'b1;
            end else begin
              state_nxt = ARMING;
              cnt_nxt   = ONE_CNT;
            end
          end
        end
        ARMING: begin
          if (!act) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt == LAST_CNT) begin
            state_nxt = ACTIVE;
            cnt_nxt   = '0;
            pulse_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + ONE_CNT;
          end
        end
        ACTIVE: begin
          if (!act) begin
`ifdef SWITCH_DEBOUNCER_RELEASE_DEBOUNCE_EN
            if (SINGLE) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = RELEASING;
              cnt_nxt   = ONE_CNT;
            end
`else
            state_nxt = IDLE;
`endif
          end
        end
`ifdef SWITCH_DEBOUNCER_RELEASE_DEBOUNCE_EN
        RELEASING: begin
          // A bounce back high resumes ACTIVE silently; only IDLE re-arms the pulse.
          if (act) begin
            state_nxt = ACTIVE;
            cnt_nxt   = '0;
          end else if (cnt == LAST_CNT) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + ONE_CNT;
          end
        end
`endif
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end

`ifdef SWITCH_DEBOUNCER_RELEASE_DEBOUNCE_EN
    assign level_nxt = (state_nxt == ACTIVE) || (state_nxt == RELEASING);
`else
    assign level_nxt = (state_nxt == ACTIVE);
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state   <= IDLE;
        cnt     <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        level_q <= level_nxt;
        pulse_q <= pulse_nxt;
      end
    end

    assign level_out[i] = level_q;
    assign pulse_out[i] = pulse_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) any_active <= 1'b0;
    else       any_active <= |level_out;
  end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Parametrised multi-channel switch conditioner that turns raw board push-buttons and slide switches into clean control strobes for `main_control`, such as `begin_process` and `begin_transmit`. Each channel is synchronised and must be held stable for a programmable number of cycles before it is accepted. On acceptance the channel outputs both a held level and a single-cycle pulse. It replaces the fixed per-switch 10-bit hold counters in the top level with one reusable block that scales in channel count, hold length and input polarity.

## Interface
Parameters:
- `CHANNELS`, default 2: number of independent switch channels (≥1).
- `HOLD_CYCLES`, default 1023: number of consecutive synchronised active samples required to accept a switch (≥1).
- `CNT_W`, default 10: counter width. The constraint is 2^CNT_W > HOLD_CYCLES−1.
- `SYNC_STAGES`, default 2: depth of the input synchroniser flop chain (≥2).
- `ACTIVE_LOW`, default 0: `CHANNELS`-bit mask. When a bit is 1, that channel is inverted before the synchroniser.

Ports (one clock `clock`; reset `reset` is asynchronous and active-high):
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous active-high reset.
- `sw_in`  in  CHANNELS  raw, asynchronous switch inputs.
- `level_out`  out  CHANNELS  debounced level, held while the switch is accepted.
- `pulse_out`  out  CHANNELS  one-cycle strobe on each acceptance.
- `any_active`  out  1  registered OR of all `level_out` bits.

## Operation
- Each channel is fully independent. There is no arbitration between channels.
- Input path: `sw_in[i]` XOR `ACTIVE_LOW[i]` feeds a `SYNC_STAGES` flop chain. The synchronised value is `act`.
- Per-channel states: IDLE, ARMING, ACTIVE, and RELEASING. RELEASING exists only with the macro described in Configuration.
- IDLE, `cnt`=0:
  - `act`=1 → ARMING with `cnt`=1. If `HOLD_CYCLES`=1, go straight to ACTIVE instead.
- ARMING:
  - `act`=0 → IDLE, `cnt`=0. Any single low sample restarts the count.
  - `act`=1 and `cnt`=HOLD_CYCLES−1 → ACTIVE, `cnt`=0. Set `level_out`=1 and `pulse_out`=1.
  - Otherwise increment `cnt`.
- ACTIVE: `level_out`=1 and `pulse_out`=0.
  - `act`=0 → IDLE, or → RELEASING with the macro.
- RELEASING (macro only): mirror of ARMING on low samples.
  - `act`=1 → ACTIVE, `cnt`=0, with no new pulse.
  - `HOLD_CYCLES` consecutive lows → IDLE, `level_out`=0.
- `cnt` never exceeds HOLD_CYCLES−1 and never wraps.
- A switch held forever produces exactly one pulse. A new pulse requires a return to IDLE first.

## Timing
- Reset, asynchronous: all synchroniser flops, `cnt`, state, `level_out`, `pulse_out` and `any_active` go to 0/IDLE immediately.
  - After reset the synchroniser holds the inactive value, so an ACTIVE_LOW channel tied low starts counting only after reset deasserts.
  - Reset mid-ARMING discards the partial count.
- Assertion latency, with `sw_in` active before clock edge 1 and held: `level_out` and `pulse_out` rise after edge SYNC_STAGES+HOLD_CYCLES. `pulse_out` is high for exactly one cycle.
- Release latency without the macro: `level_out` falls after edge SYNC_STAGES+1, counted from the first inactive sample.
- Release latency with the macro: `level_out` falls after edge SYNC_STAGES+HOLD_CYCLES, counted the same way.
- `any_active` lags `level_out` by one cycle.
- Simultaneous activity on several channels is fully parallel. Identical stimulus gives identical edge timing.

## Configuration
- Macro `SWITCH_DEBOUNCER_RELEASE_DEBOUNCE_EN`.
- When defined: the RELEASING state is present, and release must also be stable for `HOLD_CYCLES`.
- When undefined: the RELEASING state is absent and release is immediate, one cycle after the synchroniser, matching the legacy top-level behaviour.

## Test plan
Parameters for all scenarios unless noted: CHANNELS=2, HOLD_CYCLES=8, SYNC_STAGES=2, ACTIVE_LOW=2'b00.

1. `sw_in`=2'b01 from before edge 1, held 30 cycles.
   - `level_out[0]` and `pulse_out[0]` rise after edge 10.
   - `pulse_out[0]` returns to 0 after edge 11.
   - `any_active` rises after edge 11.
   - Channel 1 stays 0 throughout.
2. `sw_in[0]` high for 7 cycles, low for 1 cycle, then high again.
   - No acceptance from the first attempt.
   - Channel accepted after edge 10, counted from the re-rise.
   - Exactly one pulse in total.
3. Release, macro undefined: drop `sw_in[0]` while ACTIVE.
   - `level_out[0]` falls after edge 3 from the drop.
4. Release, macro defined: drop `sw_in[0]` while ACTIVE.
   - `level_out[0]` falls after edge 10 from the drop.
   - A 1-cycle re-high at drop+5 keeps `level_out[0]` high with no pulse.
5. Assert `reset` asynchronously between edges while channel 0 has `cnt`=5.
   - All outputs read 0 before the next edge.
   - After reset deasserts with `sw_in[0]` still high, acceptance needs the full 10 edges.
6. ACTIVE_LOW=2'b10, `sw_in`=2'b00.
   - Both channels are treated in parallel: channel 1 accepts after edge 10 and channel 0 never does.
   - With `sw_in`=2'b11 applied instead: channel 0 accepts after edge 10 and channel 1 stays 0.
